// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem read, decoder handoff, next-PC select
module fetch_unit #(
  parameter int PC_W     = 10,
  parameter int INST_W   = 9,
  parameter int START_PC = 0
) (
  input  logic              clk,
  input  logic              init,
  input  logic              start,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_rd,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst,
  output logic              decoder_en,
  input  logic              stall,
  input  logic              pc_load,
  input  logic [PC_W-1:0]   pc_target,
  input  logic              pc_rel,
  input  logic [5:0]        pc_off,
  input  logic              done,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);
  localparam logic [PC_W-1:0] PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [PC_W-1:0]     off_ext;

  // Offset is relative to the current instruction's PC; sum wraps modulo 2^PC_W.
  assign off_ext = {{(PC_W-6){pc_off[5]}}, pc_off};

  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC_V;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = START_PC_V;
          state_d = S_FETCH;
        end
      end
      S_FETCH:  state_d = S_LATCH;
      S_LATCH: begin
        inst_d  = imem_data;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // Halt beats stall, stall masks redirects, absolute beats relative.
        if (done) begin
          state_d = S_HALT;
        end else if (!stall) begin
          state_d = S_FETCH;
          if (pc_load)     pc_d = pc_target;
          else if (pc_rel) pc_d = pc_q + off_ext;
          else             pc_d = pc_q + PC_ONE;
        end
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  assign imem_addr  = pc_q;
  assign imem_rd    = (state_q == S_FETCH);
  assign decoder_en = (state_q == S_DECODE);
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign halted     = (state_q == S_HALT);
  assign busy       = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                      (state_q == S_DECODE) || (state_q == S_EXEC);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       init, start, stall, pc_load, pc_rel, done;
  logic [9:0] pc_target, imem_addr, pc;
  logic [5:0] pc_off;
  logic [8:0] imem_data, inst;
  logic       imem_rd, decoder_en, busy, halted;

  logic [8:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_W(10), .INST_W(9), .START_PC(0)) dut (
    .clk(clk), .init(init), .start(start),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .inst(inst), .decoder_en(decoder_en),
    .stall(stall), .pc_load(pc_load), .pc_target(pc_target),
    .pc_rel(pc_rel), .pc_off(pc_off), .done(done),
    .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_decode(input string tag);
    int n = 0;
    while (!decoder_en && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_decode_seen"}, {31'd0, decoder_en}, 32'd1);
  endtask

  // From DECODE: move into EXEC, drive the next-PC controls for one edge, then clear them.
  task automatic step_exec(input logic ld, input logic rel, input logic [5:0] off,
                           input logic [9:0] tgt, input logic dn);
    tick();
    chk("de_one_cycle", {31'd0, decoder_en}, 32'd0);
    pc_load = ld; pc_rel = rel; pc_off = off; pc_target = tgt; done = dn;
    tick();
    pc_load = 0; pc_rel = 0; pc_off = '0; pc_target = '0; done = 0;
  endtask

  initial begin
    int rd_cnt;
    int de_cnt;
    for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
    mem[0] = 9'h0A0; mem[1] = 9'h0B1; mem[2] = 9'h0C2; mem[3] = 9'h001;
    mem[5] = 9'h055; mem[10'h200] = 9'h1F0; mem[10'h010] = 9'h010;
    mem[10'h3FF] = 9'h13F; mem[10'h00E] = 9'h0EE;
    init = 1; start = 0; stall = 0; pc_load = 0; pc_rel = 0; done = 0;
    pc_target = '0; pc_off = '0;
    tick(); tick();

    chk("rst_busy",   {31'd0, busy}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_rd",     {31'd0, imem_rd}, 0);
    chk("rst_de",     {31'd0, decoder_en}, 0);
    chk("rst_inst",   {23'd0, inst}, 0);
    chk("rst_pc",     {22'd0, pc}, 0);

    // Sequential run ending in halt
    init = 0; start = 1; tick(); start = 0;
    chk("seq_fetch_rd",   {31'd0, imem_rd}, 1);
    chk("seq_fetch_addr", {22'd0, imem_addr}, 0);
    tick(); tick();
    chk("seq_first_de_latency", {31'd0, decoder_en}, 1);
    for (int k = 0; k < 4; k++) begin
      wait_decode("seq");
      chk("seq_inst", {23'd0, inst}, {23'd0, mem[k]});
      chk("seq_pc",   {22'd0, pc}, k);
      step_exec(0, 0, 6'd0, 10'd0, (k == 3));
      if (k < 3) begin
        chk("seq_next_rd",   {31'd0, imem_rd}, 1);
        chk("seq_next_addr", {22'd0, imem_addr}, k + 1);
      end
    end
    chk("seq_halted", {31'd0, halted}, 1);
    chk("seq_busy",   {31'd0, busy}, 0);
    chk("seq_halt_pc", {22'd0, pc}, 3);
    rd_cnt = 0;
    start = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (imem_rd || decoder_en) rd_cnt++;
    end
    start = 0;
    chk("halt_no_activity", rd_cnt, 0);
    chk("halt_start_ignored", {31'd0, halted}, 1);

    // Absolute redirects
    init = 1; tick(); init = 0;
    start = 1; tick(); start = 0;
    wait_decode("abs0");
    step_exec(1, 0, 6'd0, 10'd5, 0);
    chk("abs_to5", {22'd0, imem_addr}, 5);
    wait_decode("abs5");
    chk("abs5_inst", {23'd0, inst}, 9'h055);
    step_exec(1, 0, 6'd0, 10'h200, 0);
    chk("abs_rd",   {31'd0, imem_rd}, 1);
    chk("abs_addr", {22'd0, imem_addr}, 10'h200);
    wait_decode("abs200");
    chk("abs200_inst", {23'd0, inst}, 9'h1F0);
    step_exec(1, 1, 6'd3, 10'h200, 0);
    chk("abs_beats_rel", {22'd0, imem_addr}, 10'h200);

    // Relative redirects and wrap
    wait_decode("rel_a");
    step_exec(1, 0, 6'd0, 10'h010, 0);
    wait_decode("rel_b");
    step_exec(0, 1, 6'b111110, 10'd0, 0);
    chk("rel_minus2", {22'd0, imem_addr}, 10'h00E);
    wait_decode("rel_c");
    chk("rel_minus2_inst", {23'd0, inst}, 9'h0EE);
    step_exec(1, 0, 6'd0, 10'h000, 0);
    wait_decode("rel_d");
    step_exec(0, 1, 6'b111111, 10'd0, 0);
    chk("rel_wrap_neg", {22'd0, imem_addr}, 10'h3FF);
    wait_decode("rel_e");
    chk("rel_3ff_inst", {23'd0, inst}, 9'h13F);
    step_exec(0, 0, 6'd0, 10'd0, 0);
    chk("seq_wrap", {22'd0, imem_addr}, 10'h000);

    // Stall masks redirect
    wait_decode("stall");
    tick();
    stall = 1; pc_load = 1; pc_target = 10'h050;
    rd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (imem_rd) rd_cnt++;
      chk("stall_pc", {22'd0, pc}, 0);
    end
    chk("stall_no_rd", rd_cnt, 0);
    chk("stall_busy", {31'd0, busy}, 1);
    stall = 0; pc_load = 0; pc_target = '0;
    tick();
    chk("stall_release_rd",   {31'd0, imem_rd}, 1);
    chk("stall_release_addr", {22'd0, imem_addr}, 1);

    // Reset during LATCH
    tick();
    init = 1; tick(); init = 0;
    chk("mid_busy", {31'd0, busy}, 0);
    chk("mid_inst", {23'd0, inst}, 0);
    chk("mid_pc",   {22'd0, pc}, 0);
    de_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (decoder_en || imem_rd) de_cnt++;
      tick();
    end
    chk("mid_no_decode", de_cnt, 0);
    start = 1; tick(); start = 0;
    chk("mid_refetch_rd",   {31'd0, imem_rd}, 1);
    chk("mid_refetch_addr", {22'd0, imem_addr}, 0);
    wait_decode("mid");
    chk("mid_inst_refetch", {23'd0, inst}, 9'h0A0);

    // Halt beats redirect
    step_exec(1, 0, 6'd0, 10'h123, 1);
    chk("hp_halted", {31'd0, halted}, 1);
    chk("hp_pc",     {22'd0, pc}, 0);
    start = 1; tick(); tick(); start = 0;
    chk("hp_start_ignored", {31'd0, halted}, 1);
    chk("hp_no_rd", {31'd0, imem_rd}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
